wb_scoreboard: RTL and testbench
================================

Name: wb_scoreboard

Overview:
- Completion-side hazard tracker; the release end of the pipeline's RAW hazard protocol.
- Decode/issue presents each candidate instruction's source and destination registers. The scoreboard answers stall/go combinationally from registered state.
- Writeback retires destinations and releases them. Per-thread flush drops all outstanding writes of a squashed thread.
- Sits between decode/issue and the writeback stage, one instance per core.

Parameters:
NUM_THREADS, 4, hardware threads tracked; TW = $clog2(NUM_THREADS), minimum 1
NUM_REGS, 32, architectural registers per thread; RW = $clog2(NUM_REGS)
CNT_W, 2, width of per-(thread,reg) outstanding-write counter; max 2^CNT_W-1 in flight per register

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
iss_valid  in  1  issue candidate present
iss_thread  in  TW  thread of candidate
iss_src1  in  RW  source 1 (always read)
iss_has_src2  in  1  candidate reads src2 (add/sub/mul/beq/tlbwrite)
iss_src2  in  RW  source 2
iss_has_dst  in  1  candidate writes dst (add/sub/mul/ldb/ldw/mov)
iss_dst  in  RW  destination
iss_stall  out  1  candidate must not issue this cycle
wb_valid  in  1  writeback of one destination this cycle
wb_thread  in  TW  writeback thread
wb_dst  in  RW  register being written back
flush_valid  in  1  squash all outstanding writes of flush_thread
flush_thread  in  TW  thread to flush
busy  out  1  any counter nonzero (registered)
wb_underflow  out  1  sticky error: writeback to a register with zero outstanding writes

Behaviour:
- State: cnt[t][r], CNT_W bits each, plus an underflow flag. Reset clears all; after reset iss_stall=0 when nothing is pending, busy=0, wb_underflow=0. Reset mid-operation discards all outstanding entries immediately.
- pend(t,r) = cnt[t][r] != 0.
- iss_stall is combinational and asserts when iss_valid and any of the following hold:
  - pend(iss_thread, iss_src1);
  - iss_has_src2 and pend(iss_thread, iss_src2);
  - iss_has_dst and cnt[iss_thread][iss_dst] == max (saturation guard);
  - flush_valid and flush_thread == iss_thread.
- iss_stall = 0 whenever iss_valid = 0.
- Issue accepted = iss_valid & ~iss_stall. An accepted issue with iss_has_dst increments cnt[iss_thread][iss_dst] at the next edge. Latency is 1 cycle: a dependent instruction presented the following cycle sees the pending bit.
- Writeback with wb_valid: decrements cnt[wb_thread][wb_dst] at the next edge.
  - If that counter is 0, the counter stays 0 and wb_underflow sets; it holds until rst.
- Same-cycle accepted issue and writeback on the same (thread, reg): counter unchanged.
- Flush: all cnt[flush_thread][*] become 0 at the next edge.
  - A writeback to the same thread in the same cycle is ignored and does not set underflow.
  - Issue to the same thread is stalled (above).
  - Other threads are unaffected.
- busy is registered: OR of all counters after the update.
- Thread isolation: an identical register index on different threads never interacts.
- Counter arithmetic is modulo-free. Increment never occurs at max because issue is stalled; decrement never occurs at 0.

Optional Feature:
- WB_SAME_CYCLE_BYPASS_EN defined: a source is treated as not pending when a same-cycle writeback (wb_valid, same thread, same reg, no flush of that thread) brings its counter from 1 to 0. The saturation check likewise uses the post-writeback count. The consumer issues in the writeback cycle.
- Undefined: stall uses registered counters only. The consumer issues one cycle after writeback.

Test Plan:
1. Reset, then iss_valid thread0 src1=3 src2=4 has_src2=1 -> iss_stall=0, busy=0, wb_underflow=0.
2. Issue thread0 dst=5; next cycle issue thread0 src1=5 -> iss_stall=1. Then issue thread1 src1=5 -> iss_stall=0.
3. Pending r5 thread0; wb thread0 r5 at cycle N with consumer presented:
   - macro undefined: stall at N, go at N+1;
   - macro defined: go at N.
4. CNT_W=2: three accepted writes to thread2 r7, fourth issue with dst=7 -> iss_stall=1. Three writebacks -> cnt=0, busy=0.
5. Pending r1/r2 on thread1, flush_valid thread1 with same-cycle wb thread1 r1 -> both cleared next cycle, wb_underflow stays 0, thread1 issue stalled during flush cycle only.
6. wb thread3 r9 with cnt=0 -> wb_underflow=1 and sticky through later traffic; rst -> wb_underflow=0.

Source files
------------

// File: rtl/wb_scoreboard_if.sv
// wb_scoreboard_if: bundles the issue, writeback and flush buses of the
// writeback-side hazard scoreboard.
//   master : issue/writeback/flush driver (decode, writeback stage, bench)
//            drives iss_*, wb_*, flush_*; receives iss_stall, busy, wb_underflow
//   slave  : the scoreboard itself
// Signals:
//   iss_valid/iss_thread/iss_src1/iss_has_src2/iss_src2/iss_has_dst/iss_dst
//            issue candidate; iss_stall is the combinational go/stall answer
//   wb_valid/wb_thread/wb_dst      one retiring destination per cycle
//   flush_valid/flush_thread       squash all outstanding writes of a thread
//   busy                           registered: any write outstanding
//   wb_underflow                   sticky: writeback with nothing outstanding
interface wb_scoreboard_if #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_REGS    = 32
);
  localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic          iss_valid;
  logic [TW-1:0] iss_thread;
  logic [RW-1:0] iss_src1;
  logic          iss_has_src2;
  logic [RW-1:0] iss_src2;
  logic          iss_has_dst;
  logic [RW-1:0] iss_dst;
  logic          iss_stall;

  logic          wb_valid;
  logic [TW-1:0] wb_thread;
  logic [RW-1:0] wb_dst;

  logic          flush_valid;
  logic [TW-1:0] flush_thread;

  logic          busy;
  logic          wb_underflow;

  modport master (
    output iss_valid, iss_thread, iss_src1, iss_has_src2, iss_src2,
           iss_has_dst, iss_dst, wb_valid, wb_thread, wb_dst,
           flush_valid, flush_thread,
    input  iss_stall, busy, wb_underflow
  );

  modport slave (
    input  iss_valid, iss_thread, iss_src1, iss_has_src2, iss_src2,
           iss_has_dst, iss_dst, wb_valid, wb_thread, wb_dst,
           flush_valid, flush_thread,
    output iss_stall, busy, wb_underflow
  );
endinterface

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: completion-side RAW hazard tracker, one instance per core.
// Keeps an outstanding-write counter per (thread, register). Issue of an
// instruction with a destination increments its counter, writeback
// decrements it, and a per-thread flush clears every counter of that thread.
// iss_stall is a combinational answer computed from the registered counters.
// Ports:
//   clk  clock, all state updates on the rising edge
//   rst  synchronous active-high reset, clears all counters and flags
//   bus  wb_scoreboard_if.slave (issue / writeback / flush / status)
// Optional build macro:
//   WB_SAME_CYCLE_BYPASS_EN  when defined, a writeback in the current cycle
//   is folded into the stall decision so the consumer can issue in the
//   writeback cycle itself. Undefined: the stall uses registered counts only.
module wb_scoreboard #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_REGS    = 32,
  parameter int CNT_W       = 2
) (
  input  logic            clk,
  input  logic            rst,
  wb_scoreboard_if.slave  bus
);
  localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_reg  [NUM_THREADS][NUM_REGS];
  logic [CNT_W-1:0] cnt_next [NUM_THREADS][NUM_REGS];
  logic [NUM_THREADS*NUM_REGS-1:0] nz_next;

  logic busy_reg;
  logic underflow_reg;

  logic stall;
  logic accept;
  logic wb_eff;       // writeback that survives a same-thread flush
  logic underflow_hit;
  logic [CNT_W-1:0] c_src1;
  logic [CNT_W-1:0] c_src2;
  logic [CNT_W-1:0] c_dst;

  // A flush of the writeback's own thread swallows the writeback entirely,
  // so it neither decrements nor reports underflow.
  assign wb_eff = bus.wb_valid &&
                  !(bus.flush_valid && (bus.flush_thread == bus.wb_thread));

  assign accept = bus.iss_valid && !stall;

  assign underflow_hit = wb_eff && (cnt_reg[bus.wb_thread][bus.wb_dst] == '0);

  // Stall decision: counts as seen by the candidate this cycle.
  always_comb begin
    c_src1 = cnt_reg[bus.iss_thread][bus.iss_src1];
    c_src2 = cnt_reg[bus.iss_thread][bus.iss_src2];
    c_dst  = cnt_reg[bus.iss_thread][bus.iss_dst];
`ifdef WB_SAME_CYCLE_BYPASS_EN
    // Apply this cycle's writeback to the candidate's view so a count
    // dropping 1 -> 0 releases the consumer immediately.
    if (wb_eff && (bus.wb_thread == bus.iss_thread)) begin
      if ((bus.wb_dst == bus.iss_src1) && (c_src1 != '0)) c_src1 = c_src1 - CNT_W'(1);
      if ((bus.wb_dst == bus.iss_src2) && (c_src2 != '0)) c_src2 = c_src2 - CNT_W'(1);
      if ((bus.wb_dst == bus.iss_dst)  && (c_dst  != '0)) c_dst  = c_dst  - CNT_W'(1);
    end
`endif
    stall = 1'b0;
    if (bus.iss_valid) begin
      if (c_src1 != '0)                          stall = 1'b1;
      if (bus.iss_has_src2 && (c_src2 != '0))    stall = 1'b1;
      if (bus.iss_has_dst && (c_dst == CNT_MAX)) stall = 1'b1;
      if (bus.flush_valid && (bus.flush_thread == bus.iss_thread)) stall = 1'b1;
    end
  end

  // Per-entry next-count logic.
  generate
    for (genvar gt = 0; gt < NUM_THREADS; gt++) begin : g_thr
      for (genvar gr = 0; gr < NUM_REGS; gr++) begin : g_reg
        logic inc;
        logic dec;
        logic clr;
        logic [CNT_W-1:0] cur;

        assign cur = cnt_reg[gt][gr];
        assign clr = bus.flush_valid && (bus.flush_thread == TW'(gt));
        assign inc = accept && bus.iss_has_dst &&
                     (bus.iss_thread == TW'(gt)) && (bus.iss_dst == RW'(gr));
        assign dec = wb_eff &&
                     (bus.wb_thread == TW'(gt)) && (bus.wb_dst == RW'(gr));

        // Issue and writeback on the same entry cancel out. A decrement at
        // zero is held at zero (the error is flagged separately).
        assign cnt_next[gt][gr] =
            clr                            ? '0 :
            (inc && !dec)                  ? cur + CNT_W'(1) :
            (dec && !inc && (cur != '0))   ? cur - CNT_W'(1) :
                                             cur;

        assign nz_next[gt*NUM_REGS + gr] = |cnt_next[gt][gr];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          cnt_reg[t][r] <= '0;
        end
      end
      busy_reg      <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      busy_reg      <= |nz_next;
      underflow_reg <= underflow_reg || underflow_hit;
    end
  end

  assign bus.iss_stall    = stall;
  assign bus.busy         = busy_reg;
  assign bus.wb_underflow = underflow_reg;
endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard: directed, table-driven bench for wb_scoreboard.
// Each table row is one clock cycle: inputs driven after the falling edge,
// outputs compared 1 ns later (iss_stall reflects this row's inputs, busy
// and wb_underflow reflect the state left by earlier rows).
module tb_wb_scoreboard;
`ifdef WB_SAME_CYCLE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  localparam int NT = 4;
  localparam int NR = 32;
  localparam int TW = 2;
  localparam int RW = 5;

  logic clk;
  logic rst;
  int checks;
  int errors;

  wb_scoreboard_if #(.NUM_THREADS(NT), .NUM_REGS(NR)) bus ();

  wb_scoreboard #(.NUM_THREADS(NT), .NUM_REGS(NR), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int iv; int it; int s1; int h2; int s2; int hd; int d;
    int wv; int wt; int wd;
    int fv; int ft;
    int stall; int busy; int uf;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  task automatic drive(input vec_t v);
    bus.iss_valid    = v.iv[0];
    bus.iss_thread   = TW'(v.it);
    bus.iss_src1     = RW'(v.s1);
    bus.iss_has_src2 = v.h2[0];
    bus.iss_src2     = RW'(v.s2);
    bus.iss_has_dst  = v.hd[0];
    bus.iss_dst      = RW'(v.d);
    bus.wb_valid     = v.wv[0];
    bus.wb_thread    = TW'(v.wt);
    bus.wb_dst       = RW'(v.wd);
    bus.flush_valid  = v.fv[0];
    bus.flush_thread = TW'(v.ft);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  function automatic vec_t idle_vec();
    vec_t v;
    v = '{0,0,0,0,0,0,0, 0,0,0, 0,0, 0,0,0};
    return v;
  endfunction

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;

    //          iv it s1 h2 s2 hd d   wv wt wd  fv ft  stall    busy uf
    vecs[0]  = '{1, 0, 3, 1, 4, 0, 0,  0, 0, 0,  0, 0, 0,       0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 1, 5,  0, 0, 0,  0, 0, 0,       0, 0};
    vecs[2]  = '{1, 0, 5, 0, 0, 0, 0,  0, 0, 0,  0, 0, 1,       1, 0};
    vecs[3]  = '{1, 1, 5, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,       1, 0};
    vecs[4]  = '{1, 0, 5, 0, 0, 0, 0,  1, 0, 5,  0, 0, 1-BYP,   1, 0};
    vecs[5]  = '{1, 0, 5, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,       0, 0};
    vecs[6]  = '{1, 2, 0, 0, 0, 1, 7,  0, 0, 0,  0, 0, 0,       0, 0};
    vecs[7]  = '{1, 2, 0, 0, 0, 1, 7,  0, 0, 0,  0, 0, 0,       1, 0};
    vecs[8]  = '{1, 2, 0, 0, 0, 1, 7,  0, 0, 0,  0, 0, 0,       1, 0};
    vecs[9]  = '{1, 2, 0, 0, 0, 1, 7,  0, 0, 0,  0, 0, 1,       1, 0};
    vecs[10] = '{1, 2, 0, 1, 7, 0, 0,  1, 2, 7,  0, 0, 1,       1, 0};
    vecs[11] = '{1, 2, 0, 0, 0, 1, 7,  1, 2, 7,  0, 0, 0,       1, 0};
    vecs[12] = '{0, 2, 7, 0, 0, 0, 0,  1, 2, 7,  0, 0, 0,       1, 0};
    vecs[13] = '{1, 2, 7, 0, 0, 0, 0,  1, 2, 7,  0, 0, 1-BYP,   1, 0};
    vecs[14] = '{1, 2, 7, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,       0, 0};
    vecs[15] = '{1, 0, 0, 0, 0, 1, 1,  0, 0, 0,  0, 0, 0,       0, 0};
    vecs[16] = '{1, 1, 0, 0, 0, 1, 1,  0, 0, 0,  0, 0, 0,       1, 0};
    vecs[17] = '{1, 1, 0, 0, 0, 1, 2,  0, 0, 0,  0, 0, 0,       1, 0};
    vecs[18] = '{1, 1, 0, 0, 0, 0, 0,  1, 1, 1,  1, 1, 1,       1, 0};
    vecs[19] = '{1, 0, 0, 0, 0, 0, 0,  1, 1, 3,  1, 1, 0,       1, 0};
    vecs[20] = '{1, 1, 1, 1, 2, 0, 0,  0, 0, 0,  0, 0, 0,       1, 0};
    vecs[21] = '{1, 0, 1, 0, 0, 0, 0,  1, 0, 1,  0, 0, 1-BYP,   1, 0};
    vecs[22] = '{1, 0, 1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,       0, 0};
    vecs[23] = '{0, 0, 0, 0, 0, 0, 0,  1, 3, 9,  0, 0, 0,       0, 0};
    vecs[24] = '{1, 3, 0, 0, 0, 1, 9,  0, 0, 0,  0, 0, 0,       0, 1};
    vecs[25] = '{1, 3, 9, 0, 0, 0, 0,  0, 0, 0,  0, 0, 1,       1, 1};
    vecs[26] = '{0, 0, 0, 0, 0, 0, 0,  1, 3, 9,  0, 0, 0,       1, 1};
    vecs[27] = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,       0, 1};

    rst = 1'b1;
    drive(idle_vec());
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      $display("step %0d: iss v=%0d t=%0d s1=%0d s2=%0d/%0d dst=%0d/%0d wb v=%0d t=%0d r=%0d flush v=%0d t=%0d -> stall=%0d busy=%0d uf=%0d",
               i, vecs[i].iv, vecs[i].it, vecs[i].s1, vecs[i].h2, vecs[i].s2,
               vecs[i].hd, vecs[i].d, vecs[i].wv, vecs[i].wt, vecs[i].wd,
               vecs[i].fv, vecs[i].ft, bus.iss_stall, bus.busy, bus.wb_underflow);
      chk("iss_stall",    i, int'(bus.iss_stall),    vecs[i].stall);
      chk("busy",         i, int'(bus.busy),         vecs[i].busy);
      chk("wb_underflow", i, int'(bus.wb_underflow), vecs[i].uf);
    end

    // Flush of another thread must not stall; then reset mid-operation
    // discards the pending write and clears the sticky underflow flag.
    @(negedge clk);
    v = idle_vec();
    v.iv = 1; v.it = 0; v.hd = 1; v.d = 4; v.fv = 1; v.ft = 2;
    drive(v);
    #1;
    $display("seq rst: issue t0 dst4 with flush t2 -> stall=%0d", bus.iss_stall);
    chk("other_thread_flush_stall", 100, int'(bus.iss_stall), 0);

    @(negedge clk);
    drive(idle_vec());
    #1;
    $display("seq rst: idle -> busy=%0d uf=%0d", bus.busy, bus.wb_underflow);
    chk("busy_before_rst", 101, int'(bus.busy), 1);
    chk("uf_before_rst",   101, int'(bus.wb_underflow), 1);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    v = idle_vec();
    v.iv = 1; v.it = 0; v.s1 = 4;
    drive(v);
    #1;
    $display("seq rst: after reset issue t0 src1=4 -> stall=%0d busy=%0d uf=%0d",
             bus.iss_stall, bus.busy, bus.wb_underflow);
    chk("stall_after_rst", 102, int'(bus.iss_stall), 0);
    chk("busy_after_rst",  102, int'(bus.busy), 0);
    chk("uf_after_rst",    102, int'(bus.wb_underflow), 0);

    @(negedge clk);
    drive(idle_vec());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
